core_fetcher: RTL and testbench



---
 rtl/core_fetcher.sv | 106 ++++++++++
 tb/tb_core_fetcher.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetcher.sv
// Instruction fetcher: IDLE/REQ/WAIT/DONE handshake FSM between core and instruction controller.
// Define CORE_FETCHER_LINEBUF_EN to add a single-entry line buffer that short-circuits repeat fetches.
module core_fetcher #(
  parameter int unsigned MEM_ADDR_WIDTH = 8,
  parameter int unsigned MEM_DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_start,
  input  logic [MEM_ADDR_WIDTH-1:0] pc,
  output logic                      inst_val,
  input  logic                      inst_rdy,
  output logic [MEM_DATA_WIDTH-1:0] inst,
  output logic                      busy,
  output logic                      fetch_req_val,
  input  logic                      fetch_req_rdy,
  output logic [MEM_ADDR_WIDTH-1:0] fetch_req_addr,
  input  logic                      fetch_resp_val,
  output logic                      fetch_resp_rdy,
  input  logic [MEM_DATA_WIDTH-1:0] fetch_resp_inst,
  input  logic                      flush
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_DATA_WIDTH-1:0] inst_q;
  logic                      hit;
  logic [MEM_DATA_WIDTH-1:0] hit_data;

`ifdef CORE_FETCHER_LINEBUF_EN
  logic                      buf_valid_q;
  logic [MEM_ADDR_WIDTH-1:0] buf_tag_q;
  logic [MEM_DATA_WIDTH-1:0] buf_data_q;

  assign hit      = buf_valid_q && (buf_tag_q == pc);
  assign hit_data = buf_data_q;

  // Flush is applied after the fill so a concurrent flush wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      if (state_q == StWait && fetch_resp_val) begin
        buf_valid_q <= 1'b1;
        buf_tag_q   <= addr_q;
        buf_data_q  <= fetch_resp_inst;
      end
      if (flush) begin
        buf_valid_q <= 1'b0;
      end
    end
  end
`else
  logic unused_flush;

  assign hit          = 1'b0;
  assign hit_data     = '0;
  assign unused_flush = flush;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (fetch_start) state_d = hit ? StDone : StReq;
      StReq:  if (fetch_req_rdy) state_d = StWait;
      StWait: if (fetch_resp_val) state_d = StDone;
      StDone: if (inst_rdy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered straight from the next state so they never depend on inputs
  // combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      inst_q         <= '0;
      busy           <= 1'b0;
      fetch_req_val  <= 1'b0;
      fetch_resp_rdy <= 1'b0;
      inst_val       <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy           <= (state_d != StIdle);
      fetch_req_val  <= (state_d == StReq);
      fetch_resp_rdy <= (state_d == StWait);
      inst_val       <= (state_d == StDone);
      if (state_q == StIdle && fetch_start) begin
        addr_q <= pc;
        if (hit) inst_q <= hit_data;
      end
      if (state_q == StWait && fetch_resp_val) begin
        inst_q <= fetch_resp_inst;
      end
    end
  end

  assign fetch_req_addr = addr_q;
  assign inst           = inst_q;

endmodule

// File: tb/tb_core_fetcher.sv
// Scoreboard bench for core_fetcher: directed fetches, stalls, mid-fetch reset, line buffer.
module tb_core_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_start;
  logic [7:0]  pc;
  logic        inst_val;
  logic        inst_rdy;
  logic [15:0] inst;
  logic        busy;
  logic        fetch_req_val;
  logic        fetch_req_rdy;
  logic [7:0]  fetch_req_addr;
  logic        fetch_resp_val;
  logic        fetch_resp_rdy;
  logic [15:0] fetch_resp_inst;
  logic        flush;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  logic [15:0] exp_q[$];
  bit          resp_auto = 1'b1;

  core_fetcher #(
    .MEM_ADDR_WIDTH(8),
    .MEM_DATA_WIDTH(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_start    (fetch_start),
    .pc             (pc),
    .inst_val       (inst_val),
    .inst_rdy       (inst_rdy),
    .inst           (inst),
    .busy           (busy),
    .fetch_req_val  (fetch_req_val),
    .fetch_req_rdy  (fetch_req_rdy),
    .fetch_req_addr (fetch_req_addr),
    .fetch_resp_val (fetch_resp_val),
    .fetch_resp_rdy (fetch_resp_rdy),
    .fetch_resp_inst(fetch_resp_inst),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    if (a == 8'h05) return 16'hA1B2;
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction controller model: answers one cycle after each accepted request.
  initial begin
    logic       hs;
    logic [7:0] a;
    forever begin
      @(negedge clk);
      hs = fetch_req_val && fetch_req_rdy;
      a  = fetch_req_addr;
      @(posedge clk);
      #1;
      if (resp_auto) begin
        fetch_resp_val  = hs;
        fetch_resp_inst = hs ? mem_word(a) : 16'h0000;
      end
    end
  end

  // Monitor: every completed core handshake must match the oldest expected instruction.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (inst_val && inst_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", {16'h0, inst}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_inst", {16'h0, inst}, {16'h0, e});
        end
      end
    end
  end

  task automatic fetch_miss(input logic [7:0] a, input logic [15:0] e);
    exp_q.push_back(e);
    pc = a;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("req_val", fetch_req_val, 1);
    check("req_addr", fetch_req_addr, a);
    check("busy_req", busy, 1);
    tick();
    check("resp_rdy_wait", fetch_resp_rdy, 1);
    check("req_val_wait", fetch_req_val, 0);
    tick();
    check("inst_val_lat3", inst_val, 1);
    check("inst_done", inst, e);
    tick();
    check("busy_idle", busy, 0);
  endtask

  initial begin
    reset = 1'b1; fetch_start = 1'b0; pc = 8'h00; inst_rdy = 1'b1;
    fetch_req_rdy = 1'b1; fetch_resp_val = 1'b0; fetch_resp_inst = 16'h0; flush = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_inst_val", inst_val, 0);
    check("rst_busy", busy, 0);
    check("rst_req_val", fetch_req_val, 0);
    check("rst_resp_rdy", fetch_resp_rdy, 0);
    check("rst_req_addr", fetch_req_addr, 0);
    check("rst_inst", inst, 0);

    // Basic miss, minimum latency.
    fetch_miss(8'h05, 16'hA1B2);

    // Request stalled by controller for 4 cycles.
    fetch_req_rdy = 1'b0;
    exp_q.push_back(16'hCC33);
    pc = 8'h33; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_req_val", fetch_req_val, 1);
      check("stall_req_addr", fetch_req_addr, 8'h33);
      tick();
    end
    check("stall_not_wait", fetch_resp_rdy, 0);
    fetch_req_rdy = 1'b1;
    tick();
    check("stall_wait", fetch_resp_rdy, 1);
    tick();
    check("stall_inst_val", inst_val, 1);
    check("stall_inst", inst, 16'hCC33);
    tick();

    // Core stalls in DONE while fetch_start is pulsed.
    inst_rdy = 1'b0;
    exp_q.push_back(16'h817E);
    pc = 8'h7E; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      fetch_start = (i == 0);
      pc = 8'h22;
      check("hold_inst_val", inst_val, 1);
      check("hold_inst", inst, 16'h817E);
      check("hold_busy", busy, 1);
      check("hold_no_req", fetch_req_val, 0);
      tick();
    end
    fetch_start = 1'b0;
    inst_rdy = 1'b1;
    tick();
    check("hold_release_idle", busy, 0);
    check("hold_release_addr", fetch_req_addr, 8'h7E);
    tick();
    check("ignored_start_no_req", fetch_req_val, 0);

    // Reset during WAIT with a late response.
    resp_auto = 1'b0;
    pc = 8'h44; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    tick();
    check("rst_mid_in_wait", fetch_resp_rdy, 1);
    reset = 1'b1;
    fetch_resp_val = 1'b1; fetch_resp_inst = 16'hDEAD;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_resp_rdy", fetch_resp_rdy, 0);
    check("rst_mid_inst", inst, 0);
    check("rst_mid_inst_val", inst_val, 0);
    tick();
    check("late_resp_inst", inst, 0);
    check("late_resp_inst_val", inst_val, 0);
    fetch_resp_val = 1'b0;
    resp_auto = 1'b1;
    tick();

`ifdef CORE_FETCHER_LINEBUF_EN
    fetch_miss(8'h10, 16'hEF10);
    exp_q.push_back(16'hEF10);
    pc = 8'h10; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("hit_inst_val", inst_val, 1);
    check("hit_no_req", fetch_req_val, 0);
    check("hit_inst", inst, 16'hEF10);
    tick();
    check("hit_idle", busy, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_miss(8'h10, 16'hEF10);
`else
    fetch_miss(8'h10, 16'hEF10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_miss(8'h10, 16'hEF10);
`endif

    tick();
    tick();
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
